// File: rtl/uart_word_rx.sv
// Serial 8N1-style receiver that pairs consecutive characters into one word behind a valid/ready register.
// Latency: o_valid rises one cycle after the stop-bit sample of the second character of a word.
// Backpressure: one output word is held while o_valid && !i_ready; a word completing then is dropped with o_overrun.
module uart_word_rx #(
    parameter int width_byte   = 8,
    parameter int clks_per_bit = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rx_0,
    input  logic                    i_ready,
    output logic [2*width_byte-1:0] o_word,
    output logic                    o_valid,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic                    o_busy
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int BW = $clog2(width_byte + 1);
    localparam logic [CW-1:0] cnt_half = CW'(clks_per_bit / 2 - 1);
    localparam logic [CW-1:0] cnt_full = CW'(clks_per_bit - 1);
    localparam logic [BW-1:0] last_bit = BW'(width_byte - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s, rx_d;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [BW-1:0]           bit_cnt, bit_nxt;
    logic [width_byte-1:0]   shift_q, shift_nxt;
    logic [width_byte-1:0]   low_q, low_nxt;
    logic                    half_q, half_nxt;
    logic                    word_form;
    logic                    frame_bad;
    logic [2*width_byte-1:0] word_new;

    // Presetting to 1 keeps reset release from looking like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= i_rx_0;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            low_q   <= '0;
            half_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shift_q <= shift_nxt;
            low_q   <= low_nxt;
            half_q  <= half_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CW'(1);
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        low_nxt   = low_q;
        half_nxt  = half_q;
        word_form = 1'b0;
        frame_bad = 1'b0;
        word_new  = {shift_q, low_q};
        unique case (state)
            IDLE: begin
                if (!rx_s && rx_d) begin
                    cnt_nxt   = cnt_half;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt_full;
                        bit_nxt   = '0;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {rx_s, shift_q[width_byte-1:1]};
                    cnt_nxt   = cnt_full;
                    bit_nxt   = bit_cnt + BW'(1);
                    if (bit_cnt == last_bit) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    if (!rx_s) begin
                        // A bad stop also orphans any pending low half.
                        frame_bad = 1'b1;
                        half_nxt  = 1'b0;
                    end else if (!half_q) begin
                        low_nxt  = shift_q;
                        half_nxt = 1'b1;
                    end else begin
                        word_form = 1'b1;
                        half_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A word completing while the held word is being accepted replaces it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_word      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_bad;
            o_overrun   <= word_form && o_valid && !i_ready;
            if (word_form && (!o_valid || i_ready)) begin
                o_word  <= word_new;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receive front end that produces the 2×`width_byte`-bit parallel words consumed by `module_top` on `i_a`, `i_b` and `i_c`. It samples an asynchronous idle-high serial line using a fixed clock divider and deframes 8N1-style characters of `width_byte` data bits. It pairs consecutive characters into one word and presents each word on a valid/ready output register. It also flags framing errors and overruns.

## Interface
- `width_byte`, 8: data bits per serial character; the output word is 2×`width_byte` bits.
- `clks_per_bit`, 16: `clk` cycles per serial bit. Must be even and ≥4.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_rx_0`  in  1  serial line, idle high, asynchronous to `clk`.
- `i_ready`  in  1  consumer accepts `o_word` when `o_valid` and `i_ready` are both high on a rising edge.
- `o_word`  out  2×`width_byte`  assembled word: first character in the low half, second in the high half.
- `o_valid`  out  1  `o_word` holds an unconsumed word.
- `o_frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `o_overrun`  out  1  one-cycle pulse when a completed word is dropped.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- **Reset values:** `o_word`=0, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0, `o_busy`=0; FSM in IDLE; half-word flag cleared; synchronizer flops preset to 1.
- **Synchronizer:** `i_rx_0` passes through a 2-flop synchronizer giving `rx_s`. A third flop holds `rx_d`, the previous value of `rx_s`.
- **IDLE:** a start is detected when `rx_s`=0 and `rx_d`=1. On detection the bit counter loads `clks_per_bit/2 − 1` and the FSM enters START. A line held low does not retrigger; a 1→0 edge is required.
- **START:** when the counter reaches 0, sample `rx_s`.
  - Sample 1 → false start; return to IDLE with no pulse.
  - Sample 0 → load counter with `clks_per_bit − 1` and enter DATA.
- **DATA:** each time the counter reaches 0, shift `rx_s` into the character register LSB first and reload `clks_per_bit − 1`. After `width_byte` samples, enter STOP.
- **STOP:** when the counter reaches 0, sample `rx_s`, then return to IDLE.
  - Sample 1 and half-word flag clear → store the character as the low half and set the flag.
  - Sample 1 and flag set → form the word {character, stored low half} and clear the flag.
  - Sample 0 → pulse `o_frame_err`, discard the character and clear the half-word flag (any pending low half is lost).
- **Output register:** loads a formed word when `o_valid`=0, or when `o_valid`=1 and `i_ready`=1 in the same cycle; either load sets `o_valid`=1. Otherwise the new word is dropped, `o_overrun` pulses, and `o_word`/`o_valid` are unchanged.
- **Handshake:** `o_valid` clears on a handshake with no simultaneous load. `o_word` is stable while `o_valid`=1 and not accepted.
- **Reset mid-frame:** the partial character and half-word are lost; no pulses are produced. The receiver resumes at the next 1→0 edge after reset deasserts.

## Timing
- `i_rx_0` to `rx_s`: 2 cycles. Start edge detection occurs the cycle `rx_s` first reads 0.
- Sample points, counted from the detection cycle D:
  - start check at D + `clks_per_bit/2`;
  - data bit k (k=1..`width_byte`) at D + `clks_per_bit/2` + k×`clks_per_bit`;
  - stop at D + `clks_per_bit/2` + (`width_byte`+1)×`clks_per_bit`.
- `o_valid` (or `o_overrun`) rises the cycle after the stop sample of the second character. `o_frame_err` also pulses the cycle after the stop sample.
- `o_busy` is high from the cycle after D through the stop-sample cycle.
- The next start can be detected the cycle after returning to IDLE. Back-to-back characters with exactly 1 stop bit are received without loss.
- Throughput: one word per 2×(`width_byte`+2)×`clks_per_bit` cycles. `i_ready` may be held low indefinitely without corrupting an in-flight character.

## Test plan
- **Basic word:** defaults, `i_ready`=1; send 0x34 then 0x12 back-to-back → single `o_valid` pulse with `o_word`=0x1234, one cycle after the second stop sample; no error pulses.
- **Backpressure:**
  - Send 0xAA,0x55 with `i_ready`=0 → `o_word`=0x55AA held stable.
  - Send 0x01,0x02 while still not ready → `o_overrun` pulses once and `o_word` stays 0x55AA.
  - Raise `i_ready` → one handshake, then `o_valid`=0.
- **Simultaneous accept/load:** hold `i_ready`=1 while a second word completes in the same cycle the first is accepted → `o_valid` stays 1 and `o_word` updates; no overrun.
- **Framing error:** send 0x34 valid, then 0x12 with stop bit 0 → `o_frame_err` pulse and no `o_valid`. Then send 0x78,0x56 → `o_word`=0x5678 (stale low half discarded).
- **Glitch:** drive `i_rx_0` low for 4 cycles, then high → no state change beyond START; `o_busy` high for at most `clks_per_bit/2` cycles; no outputs.
- **Reset mid-frame:** assert `rst` during data bit 3 of the first character → all outputs 0 immediately (asynchronous). After release, send 0xCD,0xAB → `o_word`=0xABCD.
